// File: rtl/mcpu5_host.sv
// rtl/mcpu5_host.sv - host-side pin driver for the MCPU5plus core: clock/reset generation, program fetch, output demux
// Optional halt detection is enabled by defining MCPU5_HOST_HALT_DETECT_EN.
module mcpu5_host #(
    parameter int PHASE_LEN  = 1,
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [5:0] prog_data,
    input  logic [7:0] cpu_in,
    output logic       cpu_clk,
    output logic       cpu_rst,
    output logic [5:0] inst_out,
    output logic [7:0] pc_q,
    output logic [7:0] accu_q,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       halted
);
    localparam int         PCW    = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int         RCW    = $clog2(RST_CYCLES + 1);
    localparam logic [5:0] OP_OUT = 6'b111011;

    typedef enum logic [1:0] {HIGH_A, HIGH_B, LOW_A, LOW_B} phase_e;

    phase_e         phase_q, phase_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic [5:0]     inst_q, inst_d;
    logic [7:0]     pc_d, accu_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           freeze;
    logic [5:0]     mem [256];
`ifdef MCPU5_HOST_HALT_DETECT_EN
    logic           halted_q, halted_d;
    logic           seen_q, seen_d;
`endif

    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        pcnt_d      = pcnt_q;
        rcnt_d      = rcnt_q;
        cpu_rst_d   = cpu_rst_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        accu_d      = accu_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
`ifdef MCPU5_HOST_HALT_DETECT_EN
        halted_d    = halted_q;
        seen_d      = seen_q;
        freeze      = halted_q && run;
`else
        freeze      = 1'b0;
`endif
        if (!freeze) begin
            if (pcnt_q != PCW'(PHASE_LEN - 1)) begin
                pcnt_d = pcnt_q + PCW'(1);
            end else begin
                pcnt_d = '0;
                case (phase_q)
                    HIGH_A: begin
                        phase_d = HIGH_B;
                        pc_d    = cpu_in;
`ifdef MCPU5_HOST_HALT_DETECT_EN
                        // A BCC that lands on its own address can never leave: park the core clock high.
                        if (!cpu_rst_q) begin
                            seen_d = 1'b1;
                            if (seen_q && (cpu_in == pc_q) && (inst_q[5:4] == 2'b00)) begin
                                halted_d = 1'b1;
                                phase_d  = HIGH_A;
                            end
                        end
`endif
                    end
                    HIGH_B: begin
                        phase_d = LOW_A;
                        inst_d  = run ? mem[pc_q] : 6'd0;
                    end
                    LOW_A: begin
                        phase_d = LOW_B;
                        if (!run) begin
                            cpu_rst_d = 1'b1;
                        end else if (rcnt_q != RCW'(RST_CYCLES)) begin
                            rcnt_d = rcnt_q + RCW'(1);
                            if (rcnt_q + RCW'(1) == RCW'(RST_CYCLES)) begin
                                cpu_rst_d = 1'b0;
                            end
                        end
                    end
                    default: begin
                        phase_d = HIGH_A;
                        accu_d  = cpu_in;
                        if (!cpu_rst_q && (inst_q == OP_OUT)) begin
                            out_data_d  = cpu_in;
                            out_valid_d = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (!run) begin
            rcnt_d = '0;
`ifdef MCPU5_HOST_HALT_DETECT_EN
            halted_d = 1'b0;
`endif
        end
`ifdef MCPU5_HOST_HALT_DETECT_EN
        if (cpu_rst_q) begin
            seen_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= HIGH_A;
            pcnt_q      <= '0;
            rcnt_q      <= '0;
            cpu_rst_q   <= 1'b1;
            inst_q      <= '0;
            pc_q        <= '0;
            accu_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef MCPU5_HOST_HALT_DETECT_EN
            halted_q    <= 1'b0;
            seen_q      <= 1'b0;
`endif
        end else begin
            phase_q     <= phase_d;
            pcnt_q      <= pcnt_d;
            rcnt_q      <= rcnt_d;
            cpu_rst_q   <= cpu_rst_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            accu_q      <= accu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef MCPU5_HOST_HALT_DETECT_EN
            halted_q    <= halted_d;
            seen_q      <= seen_d;
`endif
        end
    end

    assign cpu_clk   = (phase_q == HIGH_A) || (phase_q == HIGH_B);
    assign cpu_rst   = cpu_rst_q;
    assign inst_out  = inst_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef MCPU5_HOST_HALT_DETECT_EN
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif
endmodule

// File: tb/tb_mcpu5_host.sv
// tb/tb_mcpu5_host.sv - self-checking bench for mcpu5_host with a small MCPU5plus core model per instance
module tb_mcpu5_host;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'd0;
    logic [5:0] prog_data = 6'd0;

    logic [7:0] cpu_in0, pc0, acc0, od0;
    logic [7:0] cpu_in1, pc1, acc1, od1;
    logic       ck0, crst0, ov0, h0;
    logic       ck1, crst1, ov1, h1;
    logic [5:0] inst0, inst1;

    always #5 clk = ~clk;

    mcpu5_host #(.PHASE_LEN(1), .RST_CYCLES(2)) u_fast (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .cpu_in(cpu_in0), .cpu_clk(ck0), .cpu_rst(crst0),
        .inst_out(inst0), .pc_q(pc0), .accu_q(acc0), .out_data(od0),
        .out_valid(ov0), .halted(h0)
    );

    mcpu5_host #(.PHASE_LEN(3), .RST_CYCLES(2)) u_slow (
        .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .cpu_in(cpu_in1), .cpu_clk(ck1), .cpu_rst(crst1),
        .inst_out(inst1), .pc_q(pc1), .accu_q(acc1), .out_data(od1),
        .out_valid(ov1), .halted(h1)
    );

    typedef struct packed {
        logic [7:0]      pc;
        logic [7:0]      acc;
        logic            c;
        logic [7:0][7:0] regs;
    } core_t;

    core_t core0 = '0;
    core_t core1 = '0;

    function automatic core_t core_next(input core_t s, input logic crst, input logic [5:0] ins);
        core_t      n;
        logic [8:0] sum;
        n = s;
        if (crst !== 1'b0) return '0;
        n.pc = s.pc + 8'd1;
        casez (ins)
            6'b00????: if (!s.c) n.pc = s.pc + {{4{ins[3]}}, ins[3:0]}; else n.c = 1'b0;
            6'b01????: n.acc = {4'b0000, ins[3:0]};
            6'b100???: begin
                sum   = {1'b0, s.acc} + {1'b0, s.regs[ins[2:0]]};
                n.acc = sum[7:0];
                n.c   = sum[8];
            end
            6'b101???: n.regs[ins[2:0]] = s.acc;
            6'b111000: n.acc = ~s.acc;
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge ck0) core0 <= core_next(core0, crst0, inst0);
    always @(posedge ck1) core1 <= core_next(core1, crst1, inst1);
    assign cpu_in0 = ck0 ? core0.pc : core0.acc;
    assign cpu_in1 = ck1 ? core1.pc : core1.acc;

    int pulses0 = 0, pulses1 = 0, wide0 = 0, wide1 = 0, iviol0 = 0, iviol1 = 0;
    logic ov0_p = 1'b0, ov1_p = 1'b0, ck0_p = 1'b1, ck1_p = 1'b1, rst_p = 1'b1;
    logic [5:0] i0_p = 6'd0, i1_p = 6'd0;

    always @(negedge clk) begin
        if (ov0) pulses0 <= pulses0 + 1;
        if (ov1) pulses1 <= pulses1 + 1;
        if (ov0 && ov0_p) wide0 <= wide0 + 1;
        if (ov1 && ov1_p) wide1 <= wide1 + 1;
        if (!rst && !rst_p && (inst0 != i0_p) && !ck0_p) iviol0 <= iviol0 + 1;
        if (!rst && !rst_p && (inst1 != i1_p) && !ck1_p) iviol1 <= iviol1 + 1;
        ov0_p <= ov0;
        ov1_p <= ov1;
        ck0_p <= ck0;
        ck1_p <= ck1;
        i0_p  <= inst0;
        i1_p  <= inst1;
        rst_p <= rst;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [5:0] p[8], input int len);
        run = 1'b0;
        repeat (8) @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            prog_we   = 1'b1;
            prog_addr = a[7:0];
            prog_data = (a < len) ? p[a[2:0]] : 6'd0;
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    typedef struct {
        logic [5:0] prog[8];
        int         len;
        logic [7:0] exp_out;
        int         exp_pulses;
        logic [7:0] exp_pc;
    } vec_t;

    initial begin
        vec_t       vecs[4];
        logic [3:0] pat;
        logic       hexp;
        int         s0, s1, hi, lo, lows, n;

        vecs[0] = '{prog: '{6'h15, 6'h3B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00},
                    len: 3, exp_out: 8'h05, exp_pulses: 1, exp_pc: 8'h02};
        vecs[1] = '{prog: '{6'h13, 6'h28, 6'h20, 6'h3B, 6'h00, 6'h00, 6'h00, 6'h00},
                    len: 5, exp_out: 8'h06, exp_pulses: 1, exp_pc: 8'h04};
        vecs[2] = '{prog: '{6'h10, 6'h38, 6'h3B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00},
                    len: 3, exp_out: 8'hFF, exp_pulses: 1, exp_pc: 8'h03};
        vecs[3] = '{prog: '{6'h3B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00},
                    len: 2, exp_out: 8'h00, exp_pulses: 1, exp_pc: 8'h01};
`ifdef MCPU5_HOST_HALT_DETECT_EN
        hexp = 1'b1;
`else
        hexp = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("rst_cpu_clk",   32'(ck0),   32'd1);
        chk("rst_cpu_rst",   32'(crst0), 32'd1);
        chk("rst_inst_out",  32'(inst0), 32'd0);
        chk("rst_pc",        32'(pc0),   32'd0);
        chk("rst_accu",      32'(acc0),  32'd0);
        chk("rst_out_data",  32'(od0),   32'd0);
        chk("rst_out_valid", 32'(ov0),   32'd0);
        chk("rst_halted",    32'(h0),    32'd0);

        rst = 1'b0;
        pat = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], ck0};
        end
        chk("fast_clk_pattern", 32'(pat), 32'h9);

        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (!crst0 || !crst1) n++;
        end
        chk("cpu_rst_idle", 32'(n), 32'd0);

        n = 0;
        while (ck1 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (ck1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        hi = 0;
        while (ck1 === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        lo = 0;
        while (ck1 === 1'b0 && lo < 100) begin @(negedge clk); lo++; end
        chk("slow_high_len", 32'(hi), 32'd6);
        chk("slow_low_len",  32'(lo), 32'd6);

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].prog, vecs[i].len);
            s0  = pulses0;
            s1  = pulses1;
            run = 1'b1;
            repeat (600) @(negedge clk);
            chk($sformatf("v%0d_out_fast", i),    32'(od0), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_out_slow", i),    32'(od1), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_pulses_fast", i), 32'(pulses0 - s0), 32'(vecs[i].exp_pulses));
            chk($sformatf("v%0d_pulses_slow", i), 32'(pulses1 - s1), 32'(vecs[i].exp_pulses));
            chk($sformatf("v%0d_pc_fast", i),     32'(pc0), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_pc_slow", i),     32'(pc1), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_rst_released", i), 32'({crst0, crst1}), 32'd0);
            chk($sformatf("v%0d_halted", i),      32'({h0, h1}), 32'({hexp, hexp}));
            run = 1'b0;
            repeat (8) @(negedge clk);
        end

        load(vecs[2].prog, vecs[2].len);
        run = 1'b1;
        repeat (60) @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 8'd2;
        prog_data = 6'h17;
        @(negedge clk);
        prog_we = 1'b0;
        repeat (540) @(negedge clk);
        run = 1'b0;
        repeat (20) @(negedge clk);
        s0  = pulses0;
        run = 1'b1;
        repeat (600) @(negedge clk);
        chk("rerun_out",    32'(od0), 32'hFF);
        chk("rerun_pulses", 32'(pulses0 - s0), 32'd1);
        chk("rerun_pc",     32'(pc0), 32'h03);

        lows = 0;
        repeat (24) begin
            @(negedge clk);
            if (!ck0) lows++;
        end
`ifdef MCPU5_HOST_HALT_DETECT_EN
        chk("halt_clk_frozen", 32'(lows), 32'd0);
        chk("halt_set",        32'(h0),   32'd1);
        run = 1'b0;
        @(negedge clk);
        chk("halt_cleared",    32'(h0),   32'd0);
`else
        chk("no_halt",         32'(h0),   32'd0);
        chk("clk_running",     32'(lows > 0), 32'd1);
        run = 1'b0;
        @(negedge clk);
`endif
        lows = 0;
        repeat (12) begin
            @(negedge clk);
            if (!ck0) lows++;
        end
        chk("stop_clk_running", 32'(lows > 0), 32'd1);
        chk("stop_cpu_rst",     32'(crst0),    32'd1);

        run = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pc",       32'(pc0),   32'd0);
        chk("midrst_out_data", 32'(od0),   32'd0);
        chk("midrst_accu",     32'(acc0),  32'd0);
        chk("midrst_cpu_rst",  32'(crst0), 32'd1);
        chk("midrst_cpu_clk",  32'(ck0),   32'd1);
        chk("midrst_inst",     32'(inst0), 32'd0);
        chk("midrst_halted",   32'(h0),    32'd0);
        rst = 1'b0;
        run = 1'b0;
        repeat (4) @(negedge clk);

        chk("out_valid_width_fast", 32'(wide0),  32'd0);
        chk("out_valid_width_slow", 32'(wide1),  32'd0);
        chk("inst_stable_fast",     32'(iviol0), 32'd0);
        chk("inst_stable_slow",     32'(iviol1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
